// File: rtl/sync_debounce.sv
// Per-bit stability filter with registered level and optional rise/fall/any-change pulses.
// Define SYNC_DEBOUNCE_EDGE_EN to build the pulse outputs; otherwise they are tied to 0.
module sync_debounce #(
  parameter int                 WIDTH         = 1,
  parameter int                 STABLE_CYCLES = 4,
  parameter logic [WIDTH-1:0]   RESET_VAL     = {WIDTH{1'b0}}
) (
  input  logic             clk_dst,
  input  logic             Rst,
  input  logic [WIDTH-1:0] sync_in,
  input  logic             en,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] w_accept;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] r_cnt;
      logic             w_mismatch;

      assign w_mismatch   = en & (sync_in[gi] ^ r_level[gi]);
      assign w_accept[gi] = w_mismatch & (r_cnt == CNT_LAST);

      // Any matching sample, disable, or acceptance restarts qualification.
      always_ff @(posedge clk_dst) begin
        if (Rst) begin
          r_cnt <= '0;
        end else if (!w_mismatch || w_accept[gi]) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  // An accepted change always differs from the current level, so it is a flip.
  always_ff @(posedge clk_dst) begin
    if (Rst) begin
      r_level <= RESET_VAL;
    end else begin
      r_level <= r_level ^ w_accept;
    end
  end

  assign level_out = r_level;

`ifdef SYNC_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_any;

  always_ff @(posedge clk_dst) begin
    if (Rst) begin
      r_rise <= '0;
      r_fall <= '0;
      r_any  <= 1'b0;
    end else begin
      r_rise <= w_accept & sync_in;
      r_fall <= w_accept & ~sync_in;
      r_any  <= |w_accept;
    end
  end

  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign any_change = r_any;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
  assign any_change = 1'b0;
`endif

endmodule
